nv_nvdla_noc_wr_bresp_gen: RTL and testbench



---
 rtl/nv_nvdla_noc_pkg.sv | 16 +
 rtl/nv_nvdla_noc_sync_fifo.sv | 64 ++++++
 rtl/nv_nvdla_noc_wr_bresp_gen.sv | 116 +++++++++++
 tb/tb_nv_nvdla_noc_wr_bresp_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_noc_pkg.sv
// Shared definitions for the NVDLA NoC write-response model.
package nv_nvdla_noc_pkg;

  localparam int unsigned NOC_ID_W  = 8;
  localparam int unsigned NOC_LEN_W = 2;

  // B responses are always OKAY, so bresp is not carried on a port.
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // One tracked AW burst at the default widths.
  typedef struct packed {
    logic [NOC_ID_W-1:0]  id;
    logic [NOC_LEN_W-1:0] len;
  } aw_entry_t;

endpackage

// File: rtl/nv_nvdla_noc_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
module nv_nvdla_noc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Overflowing pushes and underflowing pops are dropped.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Next pointers and flags; the top bit marks a lap so full and empty are distinct.
  always_comb begin
    wptr_d  = wptr_q + {{PTR_W{1'b0}}, push_ok};
    rptr_d  = rptr_q + {{PTR_W{1'b0}}, pop_ok};
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[PTR_W] != rptr_d[PTR_W]) &&
              (wptr_d[PTR_W-1:0] == rptr_d[PTR_W-1:0]);
  end

  // Pointer and flag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset; the flags guard every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[PTR_W-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q[PTR_W-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/nv_nvdla_noc_wr_bresp_gen.sv
// Responder-side AXI write-response generator: tracks AW bursts, counts W beats
// against awlen and returns one in-order B response per completed burst.
module nv_nvdla_noc_wr_bresp_gen
  import nv_nvdla_noc_pkg::*;
#(
  parameter int unsigned AW_DEPTH = 4,
  parameter int unsigned B_DEPTH  = 4,
  parameter int unsigned ID_W     = NOC_ID_W,
  parameter int unsigned LEN_W    = NOC_LEN_W
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             mcif2noc_axi_aw_awvalid,
  output logic             mcif2noc_axi_aw_awready,
  input  logic [ID_W-1:0]  mcif2noc_axi_aw_awid,
  input  logic [LEN_W-1:0] mcif2noc_axi_aw_awlen,
  input  logic             mcif2noc_axi_w_wvalid,
  output logic             mcif2noc_axi_w_wready,
  input  logic             mcif2noc_axi_w_wlast,
  output logic             noc2mcif_axi_b_bvalid,
  input  logic             noc2mcif_axi_b_bready,
  output logic [ID_W-1:0]  noc2mcif_axi_b_bid,
  output logic             wr_err_wlast,
  output logic [3:0]       wr_outstanding
);

  logic                    aw_full, aw_empty;
  logic                    b_full, b_empty;
  logic [ID_W+LEN_W-1:0]   aw_wdata, aw_head;
  logic [ID_W-1:0]         head_id;
  logic [LEN_W-1:0]        head_len;
  logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]              outst_q, outst_d;
  logic                    err_q, err_d;
  logic                    beat_is_last;
  logic                    aw_hs, w_hs, last_hs, b_hs;

  assign aw_wdata = {mcif2noc_axi_aw_awid, mcif2noc_axi_aw_awlen};
  assign head_id  = aw_head[ID_W+LEN_W-1:LEN_W];
  assign head_len = aw_head[LEN_W-1:0];

  assign beat_is_last = (beat_cnt_q == head_len);

  // Handshakes; ready/valid are forced low while reset is held.
  always_comb begin
    mcif2noc_axi_aw_awready = ~nvdla_core_rst & ~aw_full;
    // A full B FIFO stalls only the closing beat; no bypass even if bready is high.
    mcif2noc_axi_w_wready   = ~nvdla_core_rst & ~aw_empty & ~(b_full & beat_is_last);
    noc2mcif_axi_b_bvalid   = ~nvdla_core_rst & ~b_empty;
    aw_hs   = mcif2noc_axi_aw_awvalid & mcif2noc_axi_aw_awready;
    w_hs    = mcif2noc_axi_w_wvalid & mcif2noc_axi_w_wready;
    last_hs = w_hs & beat_is_last;
    b_hs    = noc2mcif_axi_b_bvalid & noc2mcif_axi_b_bready;
  end

  nv_nvdla_noc_sync_fifo #(
    .WIDTH (ID_W + LEN_W),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (aw_hs),
    .wdata (aw_wdata),
    .pop   (last_hs),
    .rdata (aw_head),
    .full  (aw_full),
    .empty (aw_empty)
  );

  nv_nvdla_noc_sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (B_DEPTH)
  ) u_b_fifo (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (last_hs),
    .wdata (head_id),
    .pop   (b_hs),
    .rdata (noc2mcif_axi_b_bid),
    .full  (b_full),
    .empty (b_empty)
  );

  // Next-state for beat counter, outstanding count and sticky wlast error.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (w_hs) begin
      beat_cnt_d = beat_is_last ? '0 : beat_cnt_q + LEN_W'(1);
    end
    outst_d = outst_q;
    if (aw_hs && !b_hs) begin
      outst_d = outst_q + 4'd1;
    end else if (b_hs && !aw_hs) begin
      outst_d = outst_q - 4'd1;
    end
    // Length comes from awlen; wlast is only checked.
    err_d = err_q | (w_hs & (mcif2noc_axi_w_wlast != beat_is_last));
  end

  // Top-level state registers.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      beat_cnt_q <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  assign wr_err_wlast   = err_q;
  assign wr_outstanding = outst_q;

endmodule

// File: tb/tb_nv_nvdla_noc_wr_bresp_gen.sv
// Self-checking bench for nv_nvdla_noc_wr_bresp_gen.
module tb_nv_nvdla_noc_wr_bresp_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       awvalid = 1'b0;
  logic       awready;
  logic [7:0] awid = '0;
  logic [1:0] awlen = '0;
  logic       wvalid = 1'b0;
  logic       wready;
  logic       wlast = 1'b0;
  logic       bvalid;
  logic       bready = 1'b0;
  logic [7:0] bid;
  logic       err;
  logic [3:0] outst;

  int n_cmp  = 0;
  int n_fail = 0;
  int w_hs_cnt = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  nv_nvdla_noc_wr_bresp_gen #(
    .AW_DEPTH (4),
    .B_DEPTH  (4),
    .ID_W     (8),
    .LEN_W    (2)
  ) dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rst          (rst),
    .mcif2noc_axi_aw_awvalid (awvalid),
    .mcif2noc_axi_aw_awready (awready),
    .mcif2noc_axi_aw_awid    (awid),
    .mcif2noc_axi_aw_awlen   (awlen),
    .mcif2noc_axi_w_wvalid   (wvalid),
    .mcif2noc_axi_w_wready   (wready),
    .mcif2noc_axi_w_wlast    (wlast),
    .noc2mcif_axi_b_bvalid   (bvalid),
    .noc2mcif_axi_b_bready   (bready),
    .noc2mcif_axi_b_bid      (bid),
    .wr_err_wlast            (err),
    .wr_outstanding          (outst)
  );

  typedef struct {
    logic       awv;
    logic [7:0] aid;
    logic [1:0] alen;
    logic       wv;
    logic       wl;
    logic       br;
    logic       e_awr;
    logic       e_wr;
    logic       e_bv;
    logic [7:0] e_bid;
    logic [3:0] e_out;
  } vec_t;

  function automatic vec_t v(logic awv_a, logic [7:0] aid_a, logic [1:0] alen_a,
                             logic wv_a, logic wl_a, logic br_a, logic e_awr_a,
                             logic e_wr_a, logic e_bv_a, logic [7:0] e_bid_a,
                             logic [3:0] e_out_a);
    vec_t r;
    r.awv = awv_a; r.aid = aid_a; r.alen = alen_a;
    r.wv = wv_a; r.wl = wl_a; r.br = br_a;
    r.e_awr = e_awr_a; r.e_wr = e_wr_a; r.e_bv = e_bv_a;
    r.e_bid = e_bid_a; r.e_out = e_out_a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, settle, then record handshakes for the scoreboard.
  task automatic step(input logic r, input logic awv_a, input logic [7:0] aid_a,
                      input logic [1:0] alen_a, input logic wv_a, input logic wl_a,
                      input logic br_a);
    @(negedge clk);
    rst = r; awvalid = awv_a; awid = aid_a; awlen = alen_a;
    wvalid = wv_a; wlast = wl_a; bready = br_a;
    #1;
    if (awvalid && awready) sb.push_back(awid);
    if (wvalid && wready) w_hs_cnt++;
    if (bvalid && bready) begin
      if (sb.size() == 0) check("b_unexpected", 32'(bid), 32'hffff_ffff);
      else check("b_order", 32'(bid), 32'(sb.pop_front()));
    end
  endtask

  vec_t tbl [15];

  initial begin
    int k;
    // single beat, W before AW, then two back-to-back multi-beat bursts
    tbl[0]  = v(0, 8'h00, 2'd0, 1, 1, 0, 1, 0, 0, 8'h00, 4'd0);
    tbl[1]  = v(1, 8'h05, 2'd0, 1, 1, 0, 1, 0, 0, 8'h00, 4'd0);
    tbl[2]  = v(0, 8'h00, 2'd0, 1, 1, 0, 1, 1, 0, 8'h00, 4'd1);
    tbl[3]  = v(0, 8'h00, 2'd0, 0, 0, 0, 1, 0, 1, 8'h05, 4'd1);
    tbl[4]  = v(0, 8'h00, 2'd0, 0, 0, 1, 1, 0, 1, 8'h05, 4'd1);
    tbl[5]  = v(0, 8'h00, 2'd0, 0, 0, 0, 1, 0, 0, 8'h00, 4'd0);
    tbl[6]  = v(1, 8'h01, 2'd3, 0, 0, 0, 1, 0, 0, 8'h00, 4'd0);
    tbl[7]  = v(1, 8'h02, 2'd1, 1, 0, 0, 1, 1, 0, 8'h00, 4'd1);
    tbl[8]  = v(0, 8'h00, 2'd0, 1, 0, 0, 1, 1, 0, 8'h00, 4'd2);
    tbl[9]  = v(0, 8'h00, 2'd0, 1, 0, 0, 1, 1, 0, 8'h00, 4'd2);
    tbl[10] = v(0, 8'h00, 2'd0, 1, 1, 0, 1, 1, 0, 8'h00, 4'd2);
    tbl[11] = v(0, 8'h00, 2'd0, 1, 0, 0, 1, 1, 1, 8'h01, 4'd2);
    tbl[12] = v(0, 8'h00, 2'd0, 1, 1, 1, 1, 1, 1, 8'h01, 4'd2);
    tbl[13] = v(0, 8'h00, 2'd0, 0, 0, 1, 1, 0, 1, 8'h02, 4'd1);
    tbl[14] = v(0, 8'h00, 2'd0, 0, 0, 0, 1, 0, 0, 8'h00, 4'd0);

    // Reset: outputs forced low while held.
    step(1, 1, 8'h77, 2'd0, 1, 1, 1);
    step(1, 1, 8'h77, 2'd0, 1, 1, 1);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    sb.delete();

    foreach (tbl[i]) begin
      step(0, tbl[i].awv, tbl[i].aid, tbl[i].alen, tbl[i].wv, tbl[i].wl, tbl[i].br);
      check($sformatf("v%0d_awready", i), 32'(awready), 32'(tbl[i].e_awr));
      check($sformatf("v%0d_wready", i), 32'(wready), 32'(tbl[i].e_wr));
      check($sformatf("v%0d_bvalid", i), 32'(bvalid), 32'(tbl[i].e_bv));
      if (tbl[i].e_bv) check($sformatf("v%0d_bid", i), 32'(bid), 32'(tbl[i].e_bid));
      check($sformatf("v%0d_outst", i), 32'(outst), 32'(tbl[i].e_out));
    end
    check("tbl_err", 32'(err), 32'd0);

    // B back-pressure: five single-beat bursts with bready low.
    w_hs_cnt = 0;
    for (int i = 0; i < 5; i++) step(0, 1, 8'h10 + 8'(i), 2'd0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 2'd0, 1, 1, 0);
      check("bp_wready_stall", 32'(wready), 32'd0);
    end
    check("bp_bvalid", 32'(bvalid), 32'd1);
    check("bp_bid_head", 32'(bid), 32'h10);
    check("bp_outst", 32'(outst), 32'd5);
    check("bp_w_count", 32'(w_hs_cnt), 32'd4);
    for (k = 0; k < 20; k++) begin
      step(0, 0, 8'h00, 2'd0, (w_hs_cnt < 5), 1, 1);
      if (sb.size() == 0 && w_hs_cnt == 5) break;
    end
    if (k == 20) check("bp_drain_timeout", 32'(k), 32'd0);
    step(0, 0, 8'h00, 2'd0, 0, 0, 1);
    check("bp_drained_outst", 32'(outst), 32'd0);
    check("bp_drained_bvalid", 32'(bvalid), 32'd0);

    // wlast asserted early: flag sets, B still waits for the counted last beat.
    step(0, 1, 8'h33, 2'd1, 0, 0, 0);
    step(0, 0, 8'h00, 2'd0, 1, 1, 0);
    check("err_beat0_wready", 32'(wready), 32'd1);
    step(0, 0, 8'h00, 2'd0, 0, 0, 0);
    check("err_set", 32'(err), 32'd1);
    check("err_no_early_b", 32'(bvalid), 32'd0);
    step(0, 0, 8'h00, 2'd0, 1, 1, 0);
    step(0, 0, 8'h00, 2'd0, 0, 0, 0);
    check("err_b_valid", 32'(bvalid), 32'd1);
    check("err_b_id", 32'(bid), 32'h33);
    step(0, 0, 8'h00, 2'd0, 0, 0, 1);
    step(0, 0, 8'h00, 2'd0, 0, 0, 0);
    check("err_sticky", 32'(err), 32'd1);
    check("err_outst", 32'(outst), 32'd0);

    // Reset with two bursts mid-flight.
    step(0, 1, 8'h40, 2'd3, 0, 0, 0);
    step(0, 1, 8'h41, 2'd1, 1, 0, 0);
    step(0, 0, 8'h00, 2'd0, 1, 0, 0);
    step(0, 0, 8'h00, 2'd0, 0, 0, 0);
    check("mid_outst", 32'(outst), 32'd2);
    step(1, 0, 8'h00, 2'd0, 0, 0, 1);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    step(1, 0, 8'h00, 2'd0, 0, 0, 1);
    sb.delete();
    step(0, 0, 8'h00, 2'd0, 0, 0, 1);
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_bvalid", 32'(bvalid), 32'd0);
    check("post_rst_outst", 32'(outst), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_wready", 32'(wready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 2'd0, 1, 1, 1);
      check("no_stale_b", 32'(bvalid), 32'd0);
    end
    step(0, 1, 8'h55, 2'd0, 0, 0, 1);
    step(0, 0, 8'h00, 2'd0, 1, 1, 1);
    step(0, 0, 8'h00, 2'd0, 0, 0, 1);
    check("fresh_bvalid", 32'(bvalid), 32'd1);
    step(0, 0, 8'h00, 2'd0, 0, 0, 0);
    check("fresh_outst", 32'(outst), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
